// File: rtl/gpr_port_scheduler.sv
// gpr_port_scheduler: serialises rs1/rs2 operand reads over one RF read port
// and round-robin arbitrates two writeback sources onto one RF write port.
module gpr_port_scheduler #(
  parameter bit BYPASS = 1'b1
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_reqValid,
  output logic        o_reqReady,
  input  logic [4:0]  i_rs1Addr,
  input  logic [4:0]  i_rs2Addr,
  input  logic        i_needRs2,
  output logic        o_rspValid,
  input  logic        i_rspReady,
  output logic [31:0] o_rs1Data,
  output logic [31:0] o_rs2Data,
  output logic [4:0]  o_rfRdAddr,
  input  logic [31:0] i_rfRdData,
  input  logic        i_wbAValid,
  input  logic [4:0]  i_wbAAddr,
  input  logic [31:0] i_wbAData,
  output logic        o_wbAReady,
  input  logic        i_wbBValid,
  input  logic [4:0]  i_wbBAddr,
  input  logic [31:0] i_wbBData,
  output logic        o_wbBReady,
  output logic [4:0]  o_rfWrAddr,
  output logic [31:0] o_rfWrData
);
  typedef enum logic [1:0] {IDLE, RD1, RD2, RESP} state_t;
  state_t      state_q, state_d;
  logic [4:0]  rs1a_q, rs1a_d, rs2a_q, rs2a_d;
  logic        need2_q, need2_d, ptr_q, ptr_d, gnt_a, gnt_b;
  logic [31:0] rs1_q, rs1_d, rs2_q, rs2_d, cap;
  // ptr_q = 1 means B was granted last, so A wins the next contention
  assign gnt_a      = i_wbAValid && (!i_wbBValid || ptr_q);
  assign gnt_b      = i_wbBValid && !gnt_a;
  assign ptr_d      = gnt_a ? 1'b0 : gnt_b ? 1'b1 : ptr_q;
  assign o_wbAReady = gnt_a;
  assign o_wbBReady = gnt_b;
  assign o_rfWrAddr = gnt_a ? i_wbAAddr : gnt_b ? i_wbBAddr : 5'd0;
  assign o_rfWrData = (o_rfWrAddr == 5'd0) ? 32'd0 : gnt_a ? i_wbAData : i_wbBData;
  assign o_reqReady = state_q == IDLE;
  assign o_rspValid = state_q == RESP;
  assign o_rs1Data  = rs1_q;
  assign o_rs2Data  = rs2_q;
  assign o_rfRdAddr = (state_q == RD1) ? rs1a_q : (state_q == RD2) ? rs2a_q : 5'd0;
  assign cap = (o_rfRdAddr == 5'd0) ? 32'd0 :
               (BYPASS && o_rfWrAddr == o_rfRdAddr) ? o_rfWrData : i_rfRdData;
  always_comb begin
    state_d = state_q;
    rs1a_d  = rs1a_q;
    rs2a_d  = rs2a_q;
    need2_d = need2_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    unique case (state_q)
      IDLE: if (i_reqValid) begin
        rs1a_d  = i_rs1Addr;
        rs2a_d  = i_rs2Addr;
        need2_d = i_needRs2;
        state_d = RD1;
      end
      RD1: begin
        rs1_d   = cap;
        rs2_d   = need2_q ? rs2_q : 32'd0;
        state_d = need2_q ? RD2 : RESP;
      end
      RD2: begin
        rs2_d   = cap;
        state_d = RESP;
      end
      RESP: state_d = i_rspReady ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
      rs1a_q  <= 5'd0;
      rs2a_q  <= 5'd0;
      need2_q <= 1'b0;
      rs1_q   <= 32'd0;
      rs2_q   <= 32'd0;
      ptr_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      rs1a_q  <= rs1a_d;
      rs2a_q  <= rs2a_d;
      need2_q <= need2_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      ptr_q   <= ptr_d;
    end
  end
endmodule

// File: tb/tb_gpr_port_scheduler.sv
// tb_gpr_port_scheduler: directed bench for gpr_port_scheduler; runs a
// BYPASS=1 and a BYPASS=0 instance in lockstep against a small register file.
module tb_gpr_port_scheduler;
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, need = 1'b0, rsp_ready = 1'b0;
  logic [4:0] rs1 = 5'd0, rs2 = 5'd0, waa = 5'd0, wba = 5'd0;
  logic wav = 1'b0, wbv = 1'b0;
  logic [31:0] wad = 32'd0, wbd = 32'd0;
  logic req_ready, rsp_valid, wa_rdy, wb_rdy;
  logic [31:0] rs1_d1, rs2_d1, rd_data1, wr_data;
  logic [4:0] rd_addr1, wr_addr;
  logic req_ready0, rsp_valid0, wa_rdy0, wb_rdy0;
  logic [31:0] rs1_d0, rs2_d0, rd_data0, wr_data0;
  logic [4:0] rd_addr0, wr_addr0;
  logic [31:0] rf [32];
  int n_vec = 0, n_bad = 0;
  always #5 clk = ~clk;
  gpr_port_scheduler #(.BYPASS(1'b1)) u1 (
    .i_clock(clk), .i_reset(rst), .i_reqValid(req_valid), .o_reqReady(req_ready),
    .i_rs1Addr(rs1), .i_rs2Addr(rs2), .i_needRs2(need), .o_rspValid(rsp_valid),
    .i_rspReady(rsp_ready), .o_rs1Data(rs1_d1), .o_rs2Data(rs2_d1),
    .o_rfRdAddr(rd_addr1), .i_rfRdData(rd_data1),
    .i_wbAValid(wav), .i_wbAAddr(waa), .i_wbAData(wad), .o_wbAReady(wa_rdy),
    .i_wbBValid(wbv), .i_wbBAddr(wba), .i_wbBData(wbd), .o_wbBReady(wb_rdy),
    .o_rfWrAddr(wr_addr), .o_rfWrData(wr_data));
  gpr_port_scheduler #(.BYPASS(1'b0)) u0 (
    .i_clock(clk), .i_reset(rst), .i_reqValid(req_valid), .o_reqReady(req_ready0),
    .i_rs1Addr(rs1), .i_rs2Addr(rs2), .i_needRs2(need), .o_rspValid(rsp_valid0),
    .i_rspReady(rsp_ready), .o_rs1Data(rs1_d0), .o_rs2Data(rs2_d0),
    .o_rfRdAddr(rd_addr0), .i_rfRdData(rd_data0),
    .i_wbAValid(wav), .i_wbAAddr(waa), .i_wbAData(wad), .o_wbAReady(wa_rdy0),
    .i_wbBValid(wbv), .i_wbBAddr(wba), .i_wbBData(wbd), .o_wbBReady(wb_rdy0),
    .o_rfWrAddr(wr_addr0), .o_rfWrData(wr_data0));
  // Register file: reset pattern 0xA000+i, so x0 reads back nonzero
  always @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < 32; i++) rf[i] <= 32'hA000 + i;
    else if (wr_addr != 5'd0) rf[wr_addr] <= wr_data;
  assign rd_data1 = rf[rd_addr1];
  assign rd_data0 = rf[rd_addr0];
  typedef struct {
    logic av; logic [4:0] aa; logic [31:0] ad;
    logic bv; logic [4:0] ba; logic [31:0] bd;
    logic ea; logic eb; logic [4:0] ewa; logic [31:0] ewd;
  } wvec_t;
  wvec_t tbl [12];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic issue(input logic [4:0] a1, input logic [4:0] a2, input logic nd);
    @(negedge clk);
    rs1 = a1; rs2 = a2; need = nd; req_valid = 1'b1;
    #1 chk("req_ready_idle", req_ready, 1'b1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask
  task automatic wait_rsp(input int lat);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      #1 chk($sformatf("rsp_valid_T+%0d", k), rsp_valid, k == lat);
    end
  endtask
  task automatic finish_rsp;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask
  initial begin
    tbl[0]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0,  32'h0,  1'b0, 1'b0, 5'd0, 32'h0};
    tbl[1]  = '{1'b1, 5'd1, 32'h11,   1'b1, 5'd2,  32'h22, 1'b1, 1'b0, 5'd1, 32'h11};
    tbl[2]  = '{1'b1, 5'd1, 32'h11,   1'b1, 5'd2,  32'h22, 1'b0, 1'b1, 5'd2, 32'h22};
    tbl[3]  = '{1'b1, 5'd1, 32'h11,   1'b1, 5'd2,  32'h22, 1'b1, 1'b0, 5'd1, 32'h11};
    tbl[4]  = '{1'b1, 5'd1, 32'h11,   1'b1, 5'd2,  32'h22, 1'b0, 1'b1, 5'd2, 32'h22};
    tbl[5]  = '{1'b0, 5'd0, 32'h0,    1'b1, 5'd4,  32'h44, 1'b0, 1'b1, 5'd4, 32'h44};
    tbl[6]  = '{1'b1, 5'd3, 32'h33,   1'b1, 5'd2,  32'h22, 1'b1, 1'b0, 5'd3, 32'h33};
    tbl[7]  = '{1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0,  32'h0,  1'b1, 1'b0, 5'd0, 32'h0};
    tbl[8]  = '{1'b1, 5'd5, 32'h1234, 1'b0, 5'd0,  32'h0,  1'b1, 1'b0, 5'd5, 32'h1234};
    tbl[9]  = '{1'b1, 5'd6, 32'h66,   1'b1, 5'd7,  32'h77, 1'b0, 1'b1, 5'd7, 32'h77};
    tbl[10] = '{1'b0, 5'd0, 32'h0,    1'b1, 5'd0,  32'h5,  1'b0, 1'b1, 5'd0, 32'h0};
    tbl[11] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0,  32'h0,  1'b0, 1'b0, 5'd0, 32'h0};
    @(negedge clk);
    chk("reset_state", {req_ready, rsp_valid, rs1_d1, rs2_d1}, {1'b1, 1'b0, 64'd0});
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      wav = tbl[i].av; waa = tbl[i].aa; wad = tbl[i].ad;
      wbv = tbl[i].bv; wba = tbl[i].ba; wbd = tbl[i].bd;
      #1 chk($sformatf("wr_vec%0d", i), {wa_rdy, wb_rdy, wr_addr, wr_data, rd_addr1},
             {tbl[i].ea, tbl[i].eb, tbl[i].ewa, tbl[i].ewd, 5'd0});
    end
    @(negedge clk);
    wav = 1'b0; wbv = 1'b0;
    // x5 = 0x1234, x0 must read as 0 despite rf[0] = 0xA000
    issue(5'd5, 5'd0, 1'b1);
    wait_rsp(3);
    chk("s1_data", {rs1_d1, rs2_d1}, {32'h1234, 32'h0});
    chk("s1_data_nobyp", {rs1_d0, rs2_d0}, {32'h1234, 32'h0});
    chk("s1_rdaddr_resp", rd_addr1, 5'd0);
    finish_rsp();
    // Single-operand request held in RESP while x7 is overwritten
    issue(5'd7, 5'd3, 1'b0);
    wait_rsp(2);
    req_valid = 1'b1;
    wav = 1'b1; waa = 5'd7; wad = 32'hBEEF;
    for (int j = 0; j < 5; j++) begin
      #1 chk($sformatf("s2_hold%0d", j), {rsp_valid, req_ready, rs1_d1, rs2_d1},
             {1'b1, 1'b0, 32'h77, 32'h0});
      @(negedge clk);
    end
    wav = 1'b0;
    rsp_ready = 1'b1;
    #1 chk("s2_no_accept_in_resp", req_ready, 1'b0);
    @(posedge clk);
    #1 begin rsp_ready = 1'b0; req_valid = 1'b0; end
    @(negedge clk);
    #1 chk("s2_back_idle", {rsp_valid, req_ready}, {1'b0, 1'b1});
    // Bypass: B writes x9 in the RD1 cycle
    issue(5'd9, 5'd0, 1'b0);
    @(negedge clk);
    wbv = 1'b1; wba = 5'd9; wbd = 32'hCAFE;
    #1 chk("byp_rd1", {rd_addr1, wb_rdy}, {5'd9, 1'b1});
    @(negedge clk);
    wbv = 1'b0;
    #1 chk("byp_on", {rsp_valid, rs1_d1, rs2_d1}, {1'b1, 32'hCAFE, 32'h0});
    chk("byp_off", rs1_d0, 32'hA009);
    finish_rsp();
    // Reset in RD2 aborts immediately
    issue(5'd3, 5'd4, 1'b1);
    @(negedge clk);
    @(negedge clk);
    #1 chk("s3_pre_reset", {rd_addr1, rs1_d1}, {5'd4, 32'h33});
    rst = 1'b1;
    #1 chk("s3_reset_out", {rsp_valid, rs1_d1, rs2_d1, rd_addr1, req_ready},
           {1'b0, 64'd0, 5'd0, 1'b1});
    @(negedge clk);
    rst = 1'b0;
    #1 chk("s3_ready_after", req_ready, 1'b1);
    @(negedge clk);
    wav = 1'b1; waa = 5'd8; wad = 32'h88;
    wbv = 1'b1; wba = 5'd10; wbd = 32'hAA;
    #1 chk("s3_ptr_reset", {wa_rdy, wb_rdy, wr_addr}, {1'b1, 1'b0, 5'd8});
    @(negedge clk);
    wav = 1'b0; wbv = 1'b0;
    issue(5'd3, 5'd4, 1'b1);
    wait_rsp(3);
    chk("s3_after_data", {rs1_d1, rs2_d1}, {32'hA003, 32'hA004});
    finish_rsp();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/gpr_port_scheduler.md
GPR_PORT_SCHEDULER -- requirements
Module: gpr_port_scheduler

Interface
REQ-001 Parameter: BYPASS, 1, when 1 a read whose address matches the write issued in the same cycle captures the write data instead of the register file output.
REQ-002 i_clock  in  1  single clock; all state updates on its rising edge.
REQ-003 i_reset  in  1  asynchronous, active-high reset.
REQ-004 i_reqValid  in  1  decode stage presents a read request.
REQ-005 o_reqReady  out  1  scheduler accepts a request this cycle.
REQ-006 i_rs1Addr, i_rs2Addr  in  5 each  source register addresses.
REQ-007 i_needRs2  in  1  request also needs rs2.
REQ-008 o_rspValid  out  1  operand response valid.
REQ-009 i_rspReady  in  1  consumer takes the response.
REQ-010 o_rs1Data, o_rs2Data  out  32 each  captured operands.
REQ-011 o_rfRdAddr  out  5  address for the register file's single combinational read port.
REQ-012 i_rfRdData  in  32  read data returned in the same cycle.
REQ-013 i_wbAValid, i_wbAAddr[4:0], i_wbAData[31:0]  in  writer A (ALU writeback).
REQ-014 o_wbAReady  out  1  writer A is granted this cycle.
REQ-015 i_wbBValid, i_wbBAddr[4:0], i_wbBData[31:0]  in  writer B (load writeback).
REQ-016 o_wbBReady  out  1  writer B is granted this cycle.
REQ-017 o_rfWrAddr  out  5  write port address; 0 means no write.
REQ-018 o_rfWrData  out  32  write port data.

Function
REQ-019 The read FSM SHALL use the states IDLE, RD1, RD2 and RESP.
REQ-020 o_reqReady SHALL be 1 only in IDLE; on reqValid&&reqReady the block latches rs1Addr, rs2Addr and needRs2 and moves to RD1.
REQ-021 RD1: o_rfRdAddr = latched rs1 and the operand is captured into o_rs1Data; next state RD2 if needRs2, else RESP.
REQ-022 RD2: o_rfRdAddr = latched rs2 and the operand is captured into o_rs2Data; next state RESP.
REQ-023 When needRs2=0, o_rs2Data SHALL be loaded with 0 in RD1.
REQ-024 RESP: o_rspValid=1 and the data is held stable until i_rspReady=1; the block then returns to IDLE and accepts no new request in that same cycle.
REQ-025 Latency from the acceptance cycle T: o_rspValid asserts at T+3 with rs2 and at T+2 without; throughput is one request per 3 or 4 cycles.
REQ-026 o_rfRdAddr SHALL be 0 in IDLE and RESP.
REQ-027 Captured operands are a snapshot; a later write to the same register does not update them while in RESP.
REQ-028 A read of address 0 SHALL capture 0 regardless of i_rfRdData.
REQ-029 With BYPASS=1, a capture whose address equals a nonzero o_rfWrAddr in that cycle SHALL take o_rfWrData; with BYPASS=0 it takes i_rfRdData.
REQ-030 Write arbitration grants at most one writer per cycle; grants are combinational from the valids and the round-robin pointer.
REQ-031 Only one writer valid: that writer is granted.
REQ-032 Both writers valid: the writer not granted most recently is granted.
REQ-033 The pointer records the last granted writer and updates on every grant.
REQ-034 o_rfWrAddr/o_rfWrData SHALL come from the granted writer; with no grant they are 0/0.
REQ-035 A granted writer with address 0 is consumed (ready=1) but produces o_rfWrAddr=0.
REQ-036 The write and read paths operate independently and concurrently.

Reset
REQ-037 While i_reset=1: state is IDLE, o_rspValid=0, o_rs1Data=o_rs2Data=0, and the pointer is set so that A wins the first contention.
REQ-038 Reset asserted mid-request SHALL abort the request immediately with no response; o_reqReady=1 in the first cycle after release.

Verification
REQ-039 Write x5=0x1234 via A, then request rs1=5, rs2=0, needRs2=1 -> response at T+3 with rs1Data=0x1234, rs2Data=0.
REQ-040 Request rs1=7, needRs2=0 -> o_rspValid at T+2, o_rs2Data=0; hold i_rspReady=0 for 5 cycles -> data stable and o_reqReady=0 throughout.
REQ-041 A and B both valid for 4 cycles (addrs 1 and 2) -> grants A,B,A,B, never both ready in one cycle.
REQ-042 BYPASS=1, writer B writes x9=0xCAFE in the RD1 cycle of a request with rs1=9 -> rs1Data=0xCAFE; with BYPASS=0 it captures the old value.
REQ-043 Writer A with addr 0 and data 0xFFFF -> o_wbAReady=1 and o_rfWrAddr=0.
REQ-044 Assert i_reset in RD2 -> o_rspValid=0 and the outputs are 0 immediately; after release a new request completes normally.
